// File: rtl/panel_clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : panel_clock_ctrl_pkg
// Brief    : Shared constants and width helper for the front-panel timing stage.
// Revision : 1.0
// ============================================================================
package panel_clock_ctrl_pkg;

    localparam int c_key_step         = 0;
    localparam int c_key_rst          = 1;
    localparam int c_div_half_default = 14_000_000;
    localparam int c_debounce_default = 560_000;

    // Counter width for a modulus of n (always at least one bit)
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/panel_clock_ctrl_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : Active-low pushbutton synchronizer, debouncer and press-edge strobe.
// Revision : 1.0
// ============================================================================
module button_debounce
    import panel_clock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_default
) (
    input  logic CLK_28,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic rise
);

    localparam int                 c_cnt_w    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync0;
    logic               r_sync1;
    logic               w_pressed;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_level_q;
    logic               r_rise;

    // Synchronizer keeps tracking the pin through rst, so a held button is
    // already visible to the debounce counter as soon as rst is released.
    always_ff @(posedge CLK_28) begin
        r_sync0 <= raw_n;
        r_sync1 <= r_sync0;
    end

    assign w_pressed = ~r_sync1;

    always_ff @(posedge CLK_28) begin
        if (rst) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_level_q <= r_level;
            r_rise    <= r_level & ~r_level_q;
            if (w_pressed == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= w_pressed;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/panel_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : panel_clock_ctrl
// Brief    : Slow auto clock divider plus debounced step/reset panel buttons.
// Revision : 1.0
// ============================================================================
module panel_clock_ctrl
    import panel_clock_ctrl_pkg::*;
#(
    parameter int DIV_HALF        = c_div_half_default,
    parameter int DEBOUNCE_CYCLES = c_debounce_default
) (
    input  logic       CLK_28,
    input  logic       rst,
    input  logic [1:0] KEY,
    input  logic       run,
    output logic       clk,
    output logic       clkTick,
    output logic       btStep,
    output logic       stepPulse,
    output logic       btRst
);

    localparam int                 c_div_w    = cnt_width(DIV_HALF);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV_HALF - 1);

    logic [c_div_w-1:0] r_div;
    logic               r_clk;
    logic               r_tick;
    logic               w_unused_rst_rise;

    // Stopping run simply freezes the count, so resuming continues mid half-period
    always_ff @(posedge CLK_28) begin
        if (rst) begin
            r_div  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (run) begin
            if (r_div == c_div_last) begin
                r_div  <= '0;
                r_clk  <= ~r_clk;
                r_tick <= ~r_clk;
            end else begin
                r_div  <= r_div + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign clk     = r_clk;
    assign clkTick = r_tick;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_button (
        .CLK_28 (CLK_28),
        .rst    (rst),
        .raw_n  (KEY[c_key_step]),
        .level  (btStep),
        .rise   (stepPulse)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_rst_button (
        .CLK_28 (CLK_28),
        .rst    (rst),
        .raw_n  (KEY[c_key_rst]),
        .level  (btRst),
        .rise   (w_unused_rst_rise)
    );

endmodule
`default_nettype wire
